// File: rtl/icache_axi_refill_pkg.sv
// Shared types and AXI constants for the icache refill path.
// Holds the default line geometry, the refill FSM state type and the line type.
package icache_axi_pkg;

  localparam int LINE_WORDS = 8;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic [31:0] line_t [LINE_WORDS];

endpackage

// File: rtl/icache_axi_refill_if.sv
// AXI4 read-only bundle (AR and R channels) between the refill engine and the interconnect.
// The master modport belongs to the refill engine; the slave modport to memory.
interface icache_axi_refill_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/icache_axi_refill.sv
// Line refill: one AXI INCR burst of LINE_WORDS beats per request, line returned with a one-cycle gnt.
// Zero-wait latency is 10 cycles; AR stalls and R gaps each add one cycle, with no combinational input-to-output path.
module icache_axi_refill #(
  parameter int          LINE_WORDS = icache_axi_pkg::LINE_WORDS,
  parameter logic [3:0]  AXI_ID     = 4'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [31:0]         req_addr,
  output logic                gnt,
  output logic [31:0]         line_data [LINE_WORDS],
  output logic                err,
  icache_axi_refill_if.master axi
);

  import icache_axi_pkg::*;

  localparam int             CW         = $clog2(LINE_WORDS);
  localparam int             OFS        = CW + 2;
  localparam logic [CW-1:0]  LAST_BEAT  = CW'(LINE_WORDS - 1);
  localparam logic [31:0]    ALIGN_MASK = ~((32'd1 << OFS) - 32'd1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q;
  logic          err_q;
  logic          beat;
  logic          beat_bad;
  logic          unused_rid;

  assign axi.arid    = AXI_ID;
  assign axi.arlen   = 8'(LINE_WORDS - 1);
  assign axi.arsize  = SIZE_4B;
  assign axi.arburst = BURST_INCR;
  assign axi.araddr  = addr_q;
  assign err         = err_q;

  // Only one burst is ever in flight, so the returned ID carries no information.
  assign unused_rid  = ^axi.rid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    gnt         = 1'b0;
    case (state)
      IDLE: if (req_valid) state_nxt = ADDR;
      ADDR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_nxt = DATA;
      end
      DATA: begin
        axi.rready = 1'b1;
        if (axi.rvalid && cnt == LAST_BEAT) state_nxt = DONE;
      end
      DONE: begin
        gnt       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign beat = (state == DATA) && axi.rvalid;

  // Framing is judged against our own beat count; the burst ends on count, not on rlast.
  assign beat_bad = (axi.rresp != RESP_OKAY)
                  || ( axi.rlast && cnt != LAST_BEAT)
                  || (!axi.rlast && cnt == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < LINE_WORDS; i++) line_data[i] <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q <= req_addr & ALIGN_MASK;
        cnt    <= '0;
        err_q  <= 1'b0;
      end
      if (beat) begin
        line_data[cnt] <= axi.rdata;
        cnt            <= cnt + 1'b1;
        err_q          <= err_q | beat_bad;
      end
    end
  end

endmodule

// File: tb/tb_icache_axi_refill.sv
// Directed bench for icache_axi_refill: a cycle-stepped AXI slave model checks latency, data, err and reset.
// Expected data is the aligned line address plus 4 per word.
module tb_icache_axi_refill;
  import icache_axi_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        gnt;
  logic        err;
  line_t       line_data;

  int total;
  int bad;

  icache_axi_refill_if axi();

  icache_axi_refill dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .line_data (line_data),
    .err       (err),
    .axi       (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"}, 32'(axi.arvalid), 32'd0);
    check({tag, "_rready"},  32'(axi.rready),  32'd0);
    check({tag, "_gnt"},     32'(gnt),         32'd0);
    check({tag, "_err"},     32'(err),         32'd0);
    check({tag, "_araddr"},  axi.araddr,       32'd0);
    check({tag, "_line0"},   line_data[0],     32'd0);
    check({tag, "_line4"},   line_data[4],     32'd0);
  endtask

  // One refill. gaps: rvalid alternates 1/0. bad_beat: beat with SLVERR.
  // last_beat: extra rlast on that beat (8 = rlast missing on final beat).
  // abort_beat: assert rst once this many beats have been accepted.
  task automatic refill(input logic [31:0] addr, input int ar_stall, input bit gaps,
                        input int bad_beat, input int last_beat, input int abort_beat,
                        input int exp_cyc, input bit exp_err, input string tag);
    logic [31:0] base;
    int  cyc;
    int  stalls;
    int  beat;
    bit  done;
    bit  gap_phase;
    base      = {addr[31:5], 5'b0};
    cyc       = 0;
    stalls    = 0;
    beat      = 0;
    done      = 1'b0;
    gap_phase = 1'b0;
    req_valid = 1'b1;
    req_addr  = addr;
    while (!done) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      // The DUT must use the latched address, not a changed req_addr.
      req_addr    = ~addr;
      axi.arready = 1'b0;
      axi.rvalid  = 1'b0;
      axi.rlast   = 1'b0;
      axi.rresp   = 2'b00;
      axi.rdata   = 32'd0;
      if (axi.arvalid) begin
        check({tag, "_araddr"}, axi.araddr, base);
        axi.arready = (stalls >= ar_stall);
        stalls++;
      end
      if (axi.rready) begin
        if (abort_beat >= 0 && beat == abort_beat) begin
          rst = 1'b1;
          #1;
          check_reset_outputs({tag, "_abort"});
          req_valid = 1'b0;
          @(negedge clk);
          rst  = 1'b0;
          done = 1'b1;
        end else if (beat < 8) begin
          axi.rvalid = gaps ? !gap_phase : 1'b1;
          gap_phase  = !gap_phase;
          if (axi.rvalid) begin
            axi.rdata = base + 32'(4 * beat);
            axi.rresp = (beat == bad_beat) ? 2'b10 : 2'b00;
            axi.rlast = (beat == last_beat) || (beat == 7 && last_beat != 8);
            beat++;
          end
        end
      end
      if (!done && gnt) begin
        req_valid = 1'b0;
        check({tag, "_gnt_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        for (int i = 0; i < 8; i++)
          check($sformatf("%s_word%0d", tag, i), line_data[i], base + 32'(4 * i));
        @(negedge clk);
        check({tag, "_gnt_pulse"}, 32'(gnt), 32'd0);
        check({tag, "_line_hold"}, line_data[7], base + 32'd28);
        done = 1'b1;
      end
      if (!done && cyc > 300) begin
        total++;
        bad++;
        $error("FAIL %s_timeout observed=%0d expected=%0d", tag, cyc, exp_cyc);
        req_valid = 1'b0;
        done      = 1'b1;
      end
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_addr    = 32'd0;
    axi.arready = 1'b0;
    axi.rid     = 4'd0;
    axi.rdata   = 32'd0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b0;
    axi.rvalid  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_arlen",   32'(axi.arlen),   32'd7);
    check("reset_arsize",  32'(axi.arsize),  32'd2);
    check("reset_arburst", 32'(axi.arburst), 32'd1);
    check("reset_arid",    32'(axi.arid),    32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    refill(32'h1FC0_0024, 0, 1'b0, -1, -1, -1, 10, 1'b0, "basic");
    refill(32'h8000_1234, 5, 1'b0, -1, -1, -1, 15, 1'b0, "ar_stall");
    refill(32'h0000_0F1C, 0, 1'b1, -1, -1, -1, 17, 1'b0, "r_gaps");
    refill(32'h2000_0040, 0, 1'b0,  3, -1, -1, 10, 1'b1, "slverr");
    refill(32'h2000_0060, 0, 1'b0, -1, -1, -1, 10, 1'b0, "after_err");
    refill(32'h3000_0000, 0, 1'b0, -1,  5, -1, 10, 1'b1, "early_last");
    refill(32'h3000_00A0, 0, 1'b0, -1,  8, -1, 10, 1'b1, "no_last");
    refill(32'h4000_0000, 0, 1'b0, -1, -1,  5,  0, 1'b0, "mid_reset");
    refill(32'h5555_5584, 0, 1'b0, -1, -1, -1, 10, 1'b0, "fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_axi_refill.md
# icache_axi_refill

Line-fill responder on the memory side of the instruction cache. It accepts a cache-line refill request from the ICache and issues one AXI4 INCR burst read of 8 words. It collects the R beats into a line buffer, then returns the whole line with a one-cycle grant. It sits between the ICache miss path and the AXI interconnect, read channels only.

## Interface
- LINE_WORDS, 8, words per cache line; sets burst length and buffer depth.
- AXI_ID, 4'd0, constant ARID driven on every burst.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  refill request, level; held until gnt.
- req_addr  in  32  miss address; bits [4:0] ignored.
- gnt  out  1  one-cycle pulse; line_data valid this cycle.
- line_data  out  32×LINE_WORDS  word i is at line base + 4i.
- err  out  1  valid with gnt: the burst had a bad response or bad framing.
- arid  out  4  equals AXI_ID.
- araddr  out  32  {req_addr[31:5], 5'b0}.
- arlen  out  8  LINE_WORDS-1 (8'd7).
- arsize  out  3  3'b010 (4 bytes).
- arburst  out  2  2'b01 (INCR).
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rid  in  4  ignored; only one burst is ever outstanding.
- rdata  in  32  read beat data.
- rresp  in  2  read response.
- rlast  in  1  last beat.
- rvalid  in  1  R valid.
- rready  out  1  R ready.

## Operation
- States are IDLE, ADDR, DATA and DONE.
- **IDLE**
  - If req_valid is high: latch the aligned address, clear the beat counter and the error flag, and go to ADDR.
- **ADDR**
  - arvalid is high and araddr is stable.
  - On arvalid && arready: go to DATA.
  - arvalid never drops before the handshake.
- **DATA**
  - rready is high for the whole state.
  - On each rvalid beat:
    - Write buf[cnt] = rdata, then cnt++.
    - Set err if rresp != 2'b00.
    - Set err if rlast is high while cnt < 7.
    - Set err if rlast is low while cnt == 7.
  - The burst ends on the beat where cnt == 7, regardless of rlast. Then go to DONE.
- **DONE**
  - gnt = 1 for exactly one cycle; line_data and err are valid.
  - Next state is IDLE.
- The beat counter is 3 bits and wraps only on burst end.
- A req_valid change during ADDR or DATA is ignored; the latched address is used.
- The requester drops req_valid in the cycle after gnt. req_valid still high in the IDLE cycle after DONE starts a new refill; this is legal and is not filtered.
- line_data holds its value until the next burst overwrites it.

## Timing
- Reset values:
  - state = IDLE.
  - arvalid, rready, gnt and err are 0.
  - araddr and line buffer are 0.
  - The arlen, arsize, arburst and arid constants are always driven.
- All outputs are registered or decoded from state; there is no combinational path from AXI inputs to outputs.
- Latency with zero-wait AXI, where req_valid is first seen high at edge 0:
  - arvalid is high after edge 0 and accepted at edge 1.
  - rready is high after edge 1; beats are sampled at edges 2–9.
  - gnt is high after edge 9, for 10 cycles total.
- Each AR stall cycle adds 1 cycle; each R gap (rvalid low) adds 1 cycle.
- Reset mid-burst immediately returns to IDLE with outputs at their reset values. The interconnect is reset in the same domain, so no drain is performed.

## Structure
- Package icache_axi_pkg holds:
  - The AXI constants BURST_INCR, SIZE_4B and RESP_OKAY.
  - The LINE_WORDS default.
  - The typedef of the state enum.
  - The line typedef, logic [31:0] line_t [LINE_WORDS].
- Single module, no sub-modules. The line buffer is an internal register array, not a RAM instance.

## Test plan
- **Basic refill:** req_addr = 32'h1FC0_0024, zero-wait slave returning data = address -> araddr = 32'h1FC0_0020, arlen = 7. gnt goes high on cycle 10, line_data[0..7] = 32'h1FC0_0020..32'h1FC0_003C, err = 0.
- **AR backpressure:** arready low for 5 cycles -> arvalid and araddr stay stable throughout; gnt goes high on cycle 15.
- **R gaps:** rvalid alternates 1/0 -> all 8 words are captured in order; gnt goes high on cycle 17; no beats are dropped.
- **Error response:** rresp = 2'b10 on beat 3 -> gnt pulses once with err = 1. The next request sees err = 0.
- **Bad framing:** rlast high on beat 5 -> the block keeps collecting until beat 7; err = 1.
- **Reset mid-burst:** rst asserted after beat 4 -> outputs go to reset values asynchronously. A fresh request afterwards completes normally with correct data.
